// File: rtl/code_validator.sv
// code_validator
//   Checks incoming codes against a software-writable 2^WIDTH x 1 legality
//   table. After ALARM_THRESH consecutive illegal codes the block enters an
//   alarm state and stops accepting codes until clear_alarm is pulsed.
//
// Optional feature: define CODE_VALIDATOR_STATS_EN to build saturating
//   ok_count / bad_count statistics counters. Without it both read as 0.
//
// Parameters
//   WIDTH        code width in bits (2..10)
//   ALARM_THRESH consecutive rejects that raise the alarm (1..255)
//   CNT_W        statistics counter width
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   in_valid     code presented
//   code         code to check
//   in_ready     code accepted this cycle when in_valid=1 (0 in alarm)
//   cfg_we       legality table write strobe
//   cfg_addr     table entry to write
//   cfg_data     1 = legal, 0 = illegal
//   clear_alarm  leave the alarm state (ignored when not in alarm)
//   out_valid    one-cycle result strobe, one cycle after acceptance
//   code_ok      result of the accepted code
//   alarm        alarm state active
//   ok_count     accepted legal codes (saturating)
//   bad_count    accepted illegal codes (saturating)
module code_validator #(
  parameter int WIDTH        = 6,
  parameter int ALARM_THRESH = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] code,
  output logic             in_ready,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic             cfg_data,
  input  logic             clear_alarm,
  output logic             out_valid,
  output logic             code_ok,
  output logic             alarm,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] bad_count
);

  localparam int DEPTH = 1 << WIDTH;
  localparam int REJ_W = $clog2(ALARM_THRESH + 1);

  typedef enum logic {
    RUN   = 1'b0,
    ALARM = 1'b1
  } state_t;

  state_t             state;
  logic [DEPTH-1:0]   legal_tbl;
  logic [REJ_W-1:0]   rej_cnt;
  logic               accept;
  logic               lookup;

  // Lookup reads the table as it stands before this edge, so a same-edge
  // write to the accepted address is not visible until the next code.
  assign accept = in_valid & in_ready;
  assign lookup = legal_tbl[code];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      in_ready  <= 1'b1;
      alarm     <= 1'b0;
      legal_tbl <= '0;
      rej_cnt   <= '0;
      out_valid <= 1'b0;
      code_ok   <= 1'b0;
    end else begin
      if (cfg_we) begin
        legal_tbl[cfg_addr] <= cfg_data;
      end
      out_valid <= accept;
      code_ok   <= accept & lookup;

      case (state)
        RUN: begin
          if (accept) begin
            if (lookup) begin
              rej_cnt <= '0;
            end else if (rej_cnt >= REJ_W'(ALARM_THRESH - 1)) begin
              // Threshold reached: counter saturates and the block stops
              // accepting; this code's result still goes out next cycle.
              rej_cnt  <= REJ_W'(ALARM_THRESH);
              state    <= ALARM;
              in_ready <= 1'b0;
              alarm    <= 1'b1;
            end else begin
              rej_cnt <= rej_cnt + REJ_W'(1);
            end
          end
        end
        ALARM: begin
          if (clear_alarm) begin
            rej_cnt  <= '0;
            state    <= RUN;
            in_ready <= 1'b1;
            alarm    <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef CODE_VALIDATOR_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ok_count  <= '0;
      bad_count <= '0;
    end else if (accept) begin
      if (lookup) begin
        if (ok_count != '1) ok_count <= ok_count + CNT_W'(1);
      end else begin
        if (bad_count != '1) bad_count <= bad_count + CNT_W'(1);
      end
    end
  end
`else
  assign ok_count  = '0;
  assign bad_count = '0;
`endif

endmodule
